// File: rtl/bp_mcore_looper_ctrl.sv
// bp_mcore_looper_ctrl: memory-mapped hardware looper that splits [global_start, global_end)
// into contiguous chunks and hands them to requesting cores in round-robin order.
module bp_mcore_looper_ctrl #(
    parameter int num_core_p       = 4,
    parameter int index_width_p    = 32,
    parameter int chunk_size_p     = 16,
    parameter int cfg_addr_width_p = 20
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          cfg_v_i,
    input  logic                          cfg_w_i,
    input  logic [cfg_addr_width_p-1:0]   cfg_addr_i,
    input  logic [$clog2(num_core_p)-1:0] cfg_src_i,
    input  logic [63:0]                   cfg_data_i,
    output logic                          cfg_ready_o,
    output logic                          cfg_v_o,
    output logic [63:0]                   cfg_data_o,
    input  logic [num_core_p-1:0]         chunk_req_i,
    output logic [num_core_p-1:0]         chunk_grant_o,
    output logic [index_width_p-1:0]      chunk_start_o,
    output logic [index_width_p-1:0]      chunk_end_o,
    output logic                          done_o
);
    localparam int lg = $clog2(num_core_p);
    localparam int iw = index_width_p;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    state_e state, state_n;

    logic [iw-1:0] gstart, gend, next_idx, last_start, last_end;
    logic [iw-1:0] grant_start, grant_end, run_end;
    logic [iw-1:0] loc_start [num_core_p];
    logic [iw-1:0] loc_end   [num_core_p];
    logic [iw:0]   step, sum;
    logic [15:0]   chunk;
    logic [lg-1:0] rr_ptr, sel, idx;
    logic [63:0]   rd_mux, rd_data;
    logic rd_v, wr, rd, a_ctrl, a_gs, a_ge, a_ls, a_le;
    logic ctrl_wr, restart, abort, clear, give;
    logic unused_ok;

    assign unused_ok = ^cfg_data_i;
    assign wr      = cfg_v_i & cfg_w_i;
    assign rd      = cfg_v_i & ~cfg_w_i;
    assign a_ctrl  = cfg_addr_i == cfg_addr_width_p'(8'h00);
    assign a_gs    = cfg_addr_i == cfg_addr_width_p'(8'h08);
    assign a_ge    = cfg_addr_i == cfg_addr_width_p'(8'h10);
    assign a_ls    = cfg_addr_i == cfg_addr_width_p'(8'h18);
    assign a_le    = cfg_addr_i == cfg_addr_width_p'(8'h20);
    assign ctrl_wr = wr & a_ctrl;
    assign restart = ctrl_wr & cfg_data_i[0] & (state != RUN);
    assign abort   = ctrl_wr & ~cfg_data_i[0] & (state == RUN);
    assign clear   = ctrl_wr & ~cfg_data_i[0] & cfg_data_i[2] & (state == DONE);
    // A control write that changes state takes priority over any same-cycle grant
    assign give    = (|chunk_req_i) & (((state == RUN) & ~abort) | ((state == DONE) & ~restart & ~clear));

    // One extra bit keeps next_idx + step from wrapping near the top of the index space
    assign step        = (chunk != '0) ? (iw+1)'(chunk) : (iw+1)'(chunk_size_p);
    assign sum         = {1'b0, next_idx} + step;
    assign run_end     = (sum > {1'b0, gend}) ? gend : sum[iw-1:0];
    assign grant_start = (state == DONE) ? gend : next_idx;
    assign grant_end   = (state == DONE) ? gend : run_end;

    always_comb begin
        sel = rr_ptr;
        idx = rr_ptr;
        for (int i = num_core_p - 1; i >= 0; i--) begin
            idx = lg'((int'(rr_ptr) + i) % num_core_p);
            sel = chunk_req_i[idx] ? idx : sel;
        end
    end

    always_comb begin
        state_n = state;
        if (restart) state_n = (gstart >= gend) ? DONE : RUN;
        else if (abort | clear) state_n = IDLE;
        else if (give & (state == RUN) & (run_end == gend)) state_n = DONE;
    end

    assign rd_mux = a_ctrl ? {32'b0, chunk, 13'b0, state == DONE, state == RUN, state != IDLE}
                  : a_gs ? 64'(gstart)
                  : a_ge ? 64'(gend)
                  : a_ls ? 64'(loc_start[cfg_src_i])
                  : a_le ? 64'(loc_end[cfg_src_i])
                  : 64'b0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            gstart     <= '0;
            gend       <= '0;
            chunk      <= '0;
            next_idx   <= '0;
            rr_ptr     <= '0;
            last_start <= '0;
            last_end   <= '0;
            rd_v       <= 1'b0;
            rd_data    <= '0;
            for (int i = 0; i < num_core_p; i++) begin
                loc_start[i] <= '0;
                loc_end[i]   <= '0;
            end
        end else begin
            state <= state_n;
            rd_v  <= rd;
            if (rd) rd_data <= rd_mux;
            if (wr & (state != RUN)) begin
                if (a_ctrl) chunk <= cfg_data_i[31:16];
                if (a_gs) gstart <= cfg_data_i[iw-1:0];
                if (a_ge) gend <= cfg_data_i[iw-1:0];
            end
            if (restart) next_idx <= gstart;
            else if (give & (state == RUN)) next_idx <= run_end;
            if (give) begin
                rr_ptr         <= (sel == lg'(num_core_p - 1)) ? '0 : sel + 1'b1;
                last_start     <= grant_start;
                last_end       <= grant_end;
                loc_start[sel] <= grant_start;
                loc_end[sel]   <= grant_end;
            end
        end
    end

    assign cfg_ready_o   = 1'b1;
    assign cfg_v_o       = rd_v;
    assign cfg_data_o    = rd_data;
    assign chunk_grant_o = give ? (num_core_p'(1) << sel) : '0;
    assign chunk_start_o = give ? grant_start : last_start;
    assign chunk_end_o   = give ? grant_end : last_end;
    assign done_o        = state == DONE;
endmodule
